// File: rtl/game_pkg.sv
// Shared definitions for the game state keeper.
//  phase_t    : game phase encoding, also driven on the phase output port
//  SCORE_MAX  : score saturation ceiling (4-digit 7-segment display)
//  *_DEF      : default tuning values for the top-level parameters
package game_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PLAY      = 3'd1,
    DYING     = 3'd2,
    GAME_OVER = 3'd3,
    WIN       = 3'd4
  } phase_t;

  localparam logic [15:0] SCORE_MAX = 16'd9999;

  localparam int unsigned HART_POINTS_DEF  = 10;
  localparam int unsigned INIT_LIVES_DEF   = 3;
  localparam int unsigned MAX_LIVES_DEF    = 7;
  localparam int unsigned WIN_SCORE_DEF    = 500;
  localparam int unsigned DEATH_FRAMES_DEF = 60;

endpackage

// File: rtl/frame_counter.sv
// Counts frame ticks while enabled and flags the tick that completes TERMINAL
// frames. The count wraps to zero on that tick, so the owner sees a one-cycle
// terminal indication and the next interval starts fresh.
//  clk      in   system clock
//  resetN   in   synchronous active-low reset
//  clear    in   force count to zero (has priority over counting)
//  enable   in   counting allowed
//  tick     in   one-clk pulse per frame
//  terminal out  combinational: this tick is the TERMINAL-th one
module frame_counter #(
  parameter int unsigned TERMINAL = 60,
  parameter int unsigned WIDTH    = 6
) (
  input  logic clk,
  input  logic resetN,
  input  logic clear,
  input  logic enable,
  input  logic tick,
  output logic terminal
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;
  logic             terminal_s;

  assign terminal_s = enable & tick & (count_q == WIDTH'(TERMINAL - 1));
  assign terminal   = terminal_s;

  // Next-count: clear wins, then count on tick, wrapping at the terminal tick.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = {WIDTH{1'b0}};
    end else if (enable & tick) begin
      if (terminal_s) begin
        count_d = {WIDTH{1'b0}};
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end else begin
      count_d = count_q;
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      count_q <= {WIDTH{1'b0}};
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/game_state_keeper.sv
// Game state keeper: latches collisions during a frame, commits them once at
// the next startOfFrame, and keeps score, lives and the game phase.
//  clk                   in   system clock
//  resetN                in   synchronous active-low reset
//  startOfFrame          in   one-clk pulse per frame
//  startKey              in   debounced start/restart button (level)
//  SingleHitPulse        in   one-clk pulse, first hit of the frame
//  collision_Smiley_Hart in   smiley/hart overlap
//  collision_ghost_Hart  in   ghost/hart overlap
//  score                 out  binary score, saturating at 9999
//  lives                 out  remaining lives
//  phase                 out  phase_t encoding
//  freeze                out  movers hold position
//  hart_respawn          out  one-clk pulse: relocate hart
//  sfx_pickup            out  one-clk pulse: pickup sound
//  sfx_lose              out  one-clk pulse: life-lost sound
// All outputs are registered; a commit is visible one clock after its
// startOfFrame.
module game_state_keeper
  import game_pkg::*;
#(
  parameter int unsigned HART_POINTS  = HART_POINTS_DEF,
  parameter int unsigned INIT_LIVES   = INIT_LIVES_DEF,
  parameter int unsigned MAX_LIVES    = MAX_LIVES_DEF,
  parameter int unsigned WIN_SCORE    = WIN_SCORE_DEF,
  parameter int unsigned DEATH_FRAMES = DEATH_FRAMES_DEF
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        startKey,
  input  logic        SingleHitPulse,
  input  logic        collision_Smiley_Hart,
  input  logic        collision_ghost_Hart,
  output logic [15:0] score,
  output logic [2:0]  lives,
  output logic [2:0]  phase,
  output logic        freeze,
  output logic        hart_respawn,
  output logic        sfx_pickup,
  output logic        sfx_lose
);

  // Starting lives can never exceed the ceiling; lives only ever decrease here.
  localparam logic [2:0]  INIT_LIVES_C  = (INIT_LIVES > MAX_LIVES) ? 3'(MAX_LIVES) : 3'(INIT_LIVES);
  localparam logic [16:0] HART_POINTS_C = 17'(HART_POINTS);
  localparam logic [16:0] WIN_SCORE_C   = 17'(WIN_SCORE);
  localparam int unsigned CNT_W         = $clog2(DEATH_FRAMES + 1);

  phase_t      phase_q, phase_d;
  logic [15:0] score_q, score_d;
  logic [2:0]  lives_q, lives_d;
  logic        freeze_q, freeze_d;
  logic        hart_respawn_q, hart_respawn_d;
  logic        sfx_pickup_q, sfx_pickup_d;
  logic        sfx_lose_q, sfx_lose_d;
  logic        sh_f_q, sh_f_d;
  logic        gh_f_q, gh_f_d;
  logic        start_key_q, start_key_d;

  logic        in_play_s;
  logic        in_dying_s;
  logic        sh_hit_s;
  logic        gh_hit_s;
  logic        sh_now_s;
  logic        gh_now_s;
  logic        commit_s;
  logic        key_rise_s;
  logic        dying_done_s;
  logic [16:0] score_sum_s;
  logic [15:0] score_inc_s;

  assign in_play_s  = (phase_q == PLAY);
  assign in_dying_s = (phase_q == DYING);

  // SingleHitPulse only ever marks the collision that is already high that
  // cycle, so it qualifies rather than widens the collision inputs.
  assign sh_hit_s = collision_Smiley_Hart | (SingleHitPulse & collision_Smiley_Hart);
  assign gh_hit_s = collision_ghost_Hart  | (SingleHitPulse & collision_ghost_Hart);

  // Flags as seen at commit include same-cycle collisions.
  assign sh_now_s = sh_f_q | (in_play_s & sh_hit_s);
  assign gh_now_s = gh_f_q | (in_play_s & gh_hit_s);
  assign commit_s = in_play_s & startOfFrame;

  assign start_key_d = startKey;
  assign key_rise_s  = startKey & ~start_key_q;

  assign score_sum_s = {1'b0, score_q} + HART_POINTS_C;

  frame_counter #(
    .TERMINAL (DEATH_FRAMES),
    .WIDTH    (CNT_W)
  ) u_death_timer (
    .clk      (clk),
    .resetN   (resetN),
    .clear    (~in_dying_s),
    .enable   (in_dying_s),
    .tick     (startOfFrame),
    .terminal (dying_done_s)
  );

  // Saturating score increment for a smiley-hart commit.
  always_comb begin
    score_inc_s = score_sum_s[15:0];
    if (score_sum_s > {1'b0, SCORE_MAX}) begin
      score_inc_s = SCORE_MAX;
    end else begin
      score_inc_s = score_sum_s[15:0];
    end
  end

  // Phase FSM next-state, score/lives update, sticky flags and pulses.
  always_comb begin
    phase_d        = phase_q;
    score_d        = score_q;
    lives_d        = lives_q;
    hart_respawn_d = 1'b0;
    sfx_pickup_d   = 1'b0;
    sfx_lose_d     = 1'b0;
    sh_f_d         = 1'b0;
    gh_f_d         = 1'b0;

    case (phase_q)
      IDLE: begin
        if (startKey) begin
          phase_d = PLAY;
          score_d = 16'd0;
          lives_d = INIT_LIVES_C;
        end else begin
          phase_d = IDLE;
        end
      end

      PLAY: begin
        if (commit_s) begin
          // Flags are consumed here (defaults clear them).
          hart_respawn_d = sh_now_s | gh_now_s;
          if (sh_now_s) begin
            score_d      = score_inc_s;
            sfx_pickup_d = 1'b1;
          end else begin
            score_d = score_q;
          end
          // A life loss outranks reaching the win score in the same frame.
          if (gh_now_s) begin
            sfx_lose_d = 1'b1;
            if (lives_q <= 3'd1) begin
              lives_d = 3'd0;
              phase_d = GAME_OVER;
            end else begin
              lives_d = lives_q - 3'd1;
              phase_d = DYING;
            end
          end else if (sh_now_s && ({1'b0, score_inc_s} >= WIN_SCORE_C)) begin
            phase_d = WIN;
          end else begin
            phase_d = PLAY;
          end
        end else begin
          sh_f_d = sh_now_s;
          gh_f_d = gh_now_s;
        end
      end

      DYING: begin
        if (dying_done_s) begin
          phase_d        = PLAY;
          hart_respawn_d = 1'b1;
        end else begin
          phase_d = DYING;
        end
      end

      GAME_OVER, WIN: begin
        // Edge, not level: a key still held from play does not restart.
        if (key_rise_s) begin
          phase_d = IDLE;
        end else begin
          phase_d = phase_q;
        end
      end

      default: begin
        phase_d = IDLE;
      end
    endcase

    freeze_d = (phase_d != PLAY);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      phase_q        <= IDLE;
      score_q        <= 16'd0;
      lives_q        <= INIT_LIVES_C;
      freeze_q       <= 1'b1;
      hart_respawn_q <= 1'b0;
      sfx_pickup_q   <= 1'b0;
      sfx_lose_q     <= 1'b0;
      sh_f_q         <= 1'b0;
      gh_f_q         <= 1'b0;
      start_key_q    <= 1'b0;
    end else begin
      phase_q        <= phase_d;
      score_q        <= score_d;
      lives_q        <= lives_d;
      freeze_q       <= freeze_d;
      hart_respawn_q <= hart_respawn_d;
      sfx_pickup_q   <= sfx_pickup_d;
      sfx_lose_q     <= sfx_lose_d;
      sh_f_q         <= sh_f_d;
      gh_f_q         <= gh_f_d;
      start_key_q    <= start_key_d;
    end
  end

  assign score        = score_q;
  assign lives        = lives_q;
  assign phase        = phase_q;
  assign freeze       = freeze_q;
  assign hart_respawn = hart_respawn_q;
  assign sfx_pickup   = sfx_pickup_q;
  assign sfx_lose     = sfx_lose_q;

endmodule

// File: tb/tb_game_state_keeper.sv
// Bench for game_state_keeper: vector table, hand-written multi-frame
// sequences and a randomized run, all checked against an event-level model.
module tb_game_state_keeper;
  import game_pkg::*;

  localparam int K_HP    = 10;
  localparam int K_INIT  = 3;
  localparam int K_WIN   = 500;
  localparam int K_DEATH = 60;
  localparam int K_SMAX  = 9999;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        startKey = 1'b0;
  logic        SingleHitPulse = 1'b0;
  logic        collision_Smiley_Hart = 1'b0;
  logic        collision_ghost_Hart = 1'b0;

  logic [15:0] score;
  logic [2:0]  lives;
  logic [2:0]  phase;
  logic        freeze, hart_respawn, sfx_pickup, sfx_lose;

  logic [15:0] score2;
  logic [2:0]  lives2;
  logic [2:0]  phase2;
  logic        freeze2, hart_respawn2, sfx_pickup2, sfx_lose2;

  game_state_keeper dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startKey(startKey),
    .SingleHitPulse(SingleHitPulse), .collision_Smiley_Hart(collision_Smiley_Hart),
    .collision_ghost_Hart(collision_ghost_Hart), .score(score), .lives(lives),
    .phase(phase), .freeze(freeze), .hart_respawn(hart_respawn),
    .sfx_pickup(sfx_pickup), .sfx_lose(sfx_lose)
  );

  // Second instance: small increment and unreachable win score, to reach saturation.
  game_state_keeper #(.HART_POINTS(5), .WIN_SCORE(10000)) dut_sat (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .startKey(startKey),
    .SingleHitPulse(SingleHitPulse), .collision_Smiley_Hart(collision_Smiley_Hart),
    .collision_ghost_Hart(collision_ghost_Hart), .score(score2), .lives(lives2),
    .phase(phase2), .freeze(freeze2), .hart_respawn(hart_respawn2),
    .sfx_pickup(sfx_pickup2), .sfx_lose(sfx_lose2)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state (frame-level rules, DYING as a countdown).
  phase_t m_phase = IDLE;
  int     m_score = 0;
  int     m_lives = K_INIT;
  int     m_left  = 0;
  bit     m_sh = 1'b0, m_gh = 1'b0, m_key_prev = 1'b0;
  bit     m_resp = 1'b0, m_pick = 1'b0, m_lose = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    bit rise, sh, gh;
    m_resp = 1'b0; m_pick = 1'b0; m_lose = 1'b0;
    if (!resetN) begin
      m_phase = IDLE; m_score = 0; m_lives = K_INIT; m_left = 0;
      m_sh = 1'b0; m_gh = 1'b0; m_key_prev = 1'b0;
      return;
    end
    rise = startKey && !m_key_prev;
    m_key_prev = startKey;
    case (m_phase)
      IDLE: if (startKey) begin m_phase = PLAY; m_score = 0; m_lives = K_INIT; end
      PLAY: begin
        sh = m_sh || collision_Smiley_Hart;
        gh = m_gh || collision_ghost_Hart;
        if (startOfFrame) begin
          m_sh = 1'b0; m_gh = 1'b0;
          if (sh) begin
            m_score = (m_score + K_HP > K_SMAX) ? K_SMAX : m_score + K_HP;
            m_pick = 1'b1;
          end
          if (sh || gh) m_resp = 1'b1;
          if (gh) begin
            m_lives = m_lives - 1;
            m_lose = 1'b1;
            if (m_lives == 0) m_phase = GAME_OVER;
            else begin m_phase = DYING; m_left = K_DEATH; end
          end else if (sh && m_score >= K_WIN) m_phase = WIN;
        end else begin
          m_sh = sh; m_gh = gh;
        end
      end
      DYING: if (startOfFrame) begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_phase = PLAY; m_resp = 1'b1; end
      end
      default: if (rise) m_phase = IDLE;
    endcase
  endtask

  // One clock: advance the model on the edge, compare the DUT just after it.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    chk("mdl_score", score, m_score);
    chk("mdl_lives", lives, m_lives);
    chk("mdl_phase", phase, m_phase);
    chk("mdl_freeze", freeze, (m_phase != PLAY));
    chk("mdl_respawn", hart_respawn, m_resp);
    chk("mdl_pickup", sfx_pickup, m_pick);
    chk("mdl_lose", sfx_lose, m_lose);
  endtask

  task automatic drive(input logic rst, input logic key, input logic sof,
                       input logic shp, input logic csh, input logic cgh);
    resetN = rst; startKey = key; startOfFrame = sof;
    SingleHitPulse = shp; collision_Smiley_Hart = csh; collision_ghost_Hart = cgh;
  endtask

  task automatic expect_out(input string name, input int sc, input int lv, input phase_t ph,
                            input logic frz, input logic rsp, input logic pk, input logic ls);
    chk({name, "_score"}, score, sc);
    chk({name, "_lives"}, lives, lv);
    chk({name, "_phase"}, phase, ph);
    chk({name, "_freeze"}, freeze, frz);
    chk({name, "_respawn"}, hart_respawn, rsp);
    chk({name, "_pickup"}, sfx_pickup, pk);
    chk({name, "_lose"}, sfx_lose, ls);
  endtask

  // One frame pulse followed by one quiet cycle.
  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    end
  endtask

  typedef struct {
    logic   rst_n, key, sof, shp, csh, cgh;
    int     sc, lv;
    phase_t ph;
    logic   frz, rsp, pk, ls;
  } vec_t;

  vec_t vecs [15];

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 3, IDLE,  1'b1, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,  0, 3, PLAY,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0,  0, 3, PLAY,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  0, 3, PLAY,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  0, 3, PLAY,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  0, 3, PLAY,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,  0, 3, PLAY,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,  0, 3, PLAY,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10, 3, PLAY,  1'b0, 1'b1, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 3, PLAY,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10, 3, PLAY,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 10, 3, PLAY,  1'b0, 1'b0, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10, 2, DYING, 1'b1, 1'b1, 1'b0, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10, 2, DYING, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10, 2, DYING, 1'b1, 1'b0, 1'b0, 1'b0};

    // Table: reset, start, smiley pickup once, ghost commit into DYING.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].rst_n, vecs[i].key, vecs[i].sof, vecs[i].shp, vecs[i].csh, vecs[i].cgh);
      cycle();
      expect_out($sformatf("vec%0d", i), vecs[i].sc, vecs[i].lv, vecs[i].ph,
                 vecs[i].frz, vecs[i].rsp, vecs[i].pk, vecs[i].ls);
    end

    // DYING lasts exactly DEATH_FRAMES frames; collisions seen there are dropped.
    frames(K_DEATH - 1);
    expect_out("dying59", 10, 2, DYING, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    expect_out("dying_end", 10, 2, PLAY, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    expect_out("respawn_1clk", 10, 2, PLAY, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    expect_out("no_stale_flags", 10, 2, PLAY, 1'b0, 1'b0, 1'b0, 1'b0);

    // Second death, then build score to 490 with one life left.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    expect_out("death2", 10, 1, DYING, 1'b1, 1'b1, 1'b0, 1'b1);
    frames(K_DEATH);
    for (int i = 0; i < 48; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    end
    expect_out("score490", 490, 1, PLAY, 1'b0, 1'b0, 1'b0, 1'b0);

    // Both collisions: score hits 500 but the last life is lost -> GAME_OVER.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1); cycle();
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    expect_out("both", 500, 0, GAME_OVER, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    end
    expect_out("key_held", 500, 0, GAME_OVER, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    expect_out("key_edge", 500, 0, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    expect_out("restart", 0, 3, PLAY, 1'b0, 1'b0, 1'b0, 1'b0);

    // Collisions in IDLE are ignored.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); cycle();
    end
    expect_out("idle_ignore", 0, 3, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    expect_out("idle_no_latch", 0, 3, PLAY, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset mid-DYING with collisions pending discards everything.
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1); cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    frames(10);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1); cycle();
    expect_out("rst_dying", 0, 3, IDLE, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0); cycle();
    expect_out("rst_clean", 0, 3, PLAY, 1'b0, 1'b0, 1'b0, 1'b0);

    // Score saturation on the second instance (commit every cycle, +5 each).
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 1999; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0); cycle();
    end
    chk("sat_9995", score2, 9995);
    cycle();
    chk("sat_9999", score2, 9999);
    chk("sat_pickup", sfx_pickup2, 1);
    cycle();
    chk("sat_hold", score2, 9999);
    chk("sat_phase", phase2, PLAY);
    chk("sat_lives", lives2, 3);
    chk("sat_freeze", freeze2, 0);
    chk("sat_respawn", hart_respawn2, 1);
    chk("sat_lose", sfx_lose2, 0);

    // Randomized run against the model.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 6000; i++) begin
      drive(($urandom_range(0, 999) != 0),
            (($urandom_range(0, 15) == 0) ? ~startKey : startKey),
            ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 29) == 0));
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
